clarke_pipe: RTL and testbench
==============================

Name: clarke_pipe

Overview:
Parametrised, pipelined successor to the single-cycle balanced Clarke transform. It converts phase-current samples (a, b[, c]) into stationary-frame alpha/beta, with a per-sample mode of balanced two-phase or general three-phase. It has a valid/ready handshake with backpressure, rounding and saturation, and a channel tag carried alongside each sample. It sits between the ADC/scaling front-end and the Park transform in the FOC datapath.

Parameters:
D_WIDTH, 18, signed sample width in and out; Q1.(D_WIDTH-3) style fixed point.
Q_BITS, 15, fractional bits of the internal coefficients.
CH_BITS, 2, width of the channel tag (up to 2^CH_BITS motors or phases-sets multiplexed).

Ports:
clk  in  1  clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample this cycle.
in_mode  in  1  0 = MODE_2PH (balanced, c ignored), 1 = MODE_3PH.
in_ch  in  CH_BITS  channel tag; returned unchanged with the result.
a, b, c  in  D_WIDTH each  signed phase samples.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
alpha, beta  out  D_WIDTH each  signed results.
out_ch  out  CH_BITS  tag of the current result.
out_sat  out  1  alpha or beta was clipped for this result.

Behaviour:
- Reset (rst=1 at an edge): all stage valids clear; out_valid=0, alpha=0, beta=0, out_ch=0, out_sat=0. In-flight samples are dropped. in_ready reads 1 from the first cycle after reset releases.
- Handshake: a transfer happens when valid && ready on the same edge. adv = !out_valid || out_ready.
  - in_ready = adv. It is combinational from out_ready, and is the only comb path.
  - All three stages shift together on adv and hold otherwise.
  - out_valid/data stay stable while out_valid && !out_ready.
- Latency: exactly 3 cycles from input accept to out_valid when there is no stall. Throughput is 1 sample per cycle. Bubbles are carried as invalid stages.
- S1 (sum), sums are D_WIDTH+2 bits, sign-extended:
  - 2PH: sA = a, sB = a + 2b, kA = ONE (2^Q_BITS), kB = ONE_DIV_SQRT3.
  - 3PH: sA = 2a - b - c, sB = b - c, kA = ONE_THIRD, kB = ONE_DIV_SQRT3.
  - Mode and channel tag are registered with the sample.
- S2 (multiply): pA = sA*kA and pB = sB*kB, signed, full width D_WIDTH+Q_BITS+3.
- S3 (scale):
  - Optionally round (see Optional Feature), then arithmetic shift right by Q_BITS.
  - Saturate to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1].
  - out_sat = clipA | clipB.
- 2PH alpha equals a bit-exactly, with or without rounding.
- No state machine beyond the valid pipeline. Mode changes take effect per sample with no flush.

Optional Feature:
CLARKE_ROUND_EN. When defined, S3 adds 2^(Q_BITS-1) before the shift, giving round-half-up. When undefined, the result is a plain arithmetic-shift truncation toward -inf. Latency and handshake are identical in both builds.

Decomposition:
- clarke_pkg holds:
  - typedef clarke_mode_e {MODE_2PH, MODE_3PH};
  - Q_BITS-dependent coefficient functions, each rounded to nearest: ONE = 2^Q, ONE_DIV_SQRT3 (18919 at Q=15), ONE_THIRD (10923 at Q=15).
- Sub-module clarke_scale_sat: rounds, shifts and saturates one product, outputs the value and a clip flag. It is instantiated twice, for alpha and beta.

Test Plan (D_WIDTH=18, Q_BITS=15):
- 2PH, a=16384, b=0 -> 3 cycles later alpha=16384; beta=9460 (ROUND_EN) or 9459 (trunc); out_sat=0.
- 2PH, a=-16384, b=0 -> beta=-9459 (ROUND_EN) or -9460 (trunc); alpha=-16384.
- 3PH:
  - a=16384, b=c=-8192 -> alpha=16385 (ROUND_EN) or 16384 (trunc); beta=0.
  - a=0, b=8192, c=-8192 -> alpha=0; beta=9460 or 9459.
- 2PH, a=b=131071 -> beta=131071, out_sat=1, alpha=131071.
- Stream 6 samples with in_ch 0..5 mod 4, holding out_ready=0 for 4 cycles mid-stream -> in_ready drops the same cycle. Results emerge in order with correct tags and none are lost or duplicated. Output stays stable while stalled.
- Assert rst for 1 cycle with 3 samples in flight -> next cycle out_valid=0 and all outputs 0. Those samples never appear. A new sample accepted afterwards appears after 3 cycles.

Source files
------------

// File: rtl/clarke_pkg.sv
// clarke_pkg: shared types and Q-format coefficient helpers for clarke_pipe.
// Coefficients are rounded to nearest at elaboration time from Q_BITS.
package clarke_pkg;

    typedef enum logic {
        MODE_2PH = 1'b0,
        MODE_3PH = 1'b1
    } clarke_mode_e;

    // floor(sqrt(n)) by bitwise search; only used on constants.
    function automatic logic [63:0] isqrt64(input logic [63:0] n);
        logic [63:0] r;
        logic [63:0] t;
        r = 64'd0;
        for (int i = 31; i >= 0; i--) begin
            t = r | (64'd1 << i);
            if (t * t <= n) begin
                r = t;
            end
        end
        return r;
    endfunction

    // 1.0 in Q(q)
    function automatic int coef_one(input int q);
        return 1 << q;
    endfunction

    // round(2^q / sqrt(3)) = round(sqrt(4^q / 3)); the extra factor of 2 in
    // the root keeps one fractional bit so the final shift rounds correctly.
    function automatic int coef_one_div_sqrt3(input int q);
        logic [63:0] n;
        n = (64'd1 << (2 * q + 2)) / 64'd3;
        return int'((isqrt64(n) + 64'd1) >> 1);
    endfunction

    // round(2^q / 3)
    function automatic int coef_one_third(input int q);
        return int'(((64'd2 << q) + 64'd3) / 64'd6);
    endfunction

endpackage

// File: rtl/clarke_scale_sat.sv
// clarke_scale_sat: converts one Q-scaled product back to D_WIDTH samples.
// Build option CLARKE_ROUND_EN: round half up before the shift; otherwise
// plain arithmetic-shift truncation toward -inf.
module clarke_scale_sat #(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15,
    parameter int P_WIDTH = D_WIDTH + Q_BITS + 3
) (
    input  logic signed [P_WIDTH-1:0] p,
    output logic signed [D_WIDTH-1:0] value,
    output logic                      clip
);

    // One guard bit so the rounding add can never wrap.
    localparam logic signed [P_WIDTH:0] MAX_V =
        {{(P_WIDTH - D_WIDTH + 2){1'b0}}, {(D_WIDTH - 1){1'b1}}};
    localparam logic signed [P_WIDTH:0] MIN_V =
        {{(P_WIDTH - D_WIDTH + 2){1'b1}}, {(D_WIDTH - 1){1'b0}}};
`ifdef CLARKE_ROUND_EN
    localparam logic signed [P_WIDTH:0] HALF_LSB =
        {{(P_WIDTH + 1 - Q_BITS){1'b0}}, 1'b1, {(Q_BITS - 1){1'b0}}};
`endif

    logic signed [P_WIDTH:0] p_ext;
    logic signed [P_WIDTH:0] p_rnd;
    logic signed [P_WIDTH:0] shifted;

    // Round (optional), rescale and clip to the output range.
    always_comb begin
        p_ext = {p[P_WIDTH-1], p};
`ifdef CLARKE_ROUND_EN
        p_rnd = p_ext + HALF_LSB;
`else
        p_rnd = p_ext;
`endif
        shifted = p_rnd >>> Q_BITS;
        if (shifted > MAX_V) begin
            value = MAX_V[D_WIDTH-1:0];
            clip  = 1'b1;
        end else if (shifted < MIN_V) begin
            value = MIN_V[D_WIDTH-1:0];
            clip  = 1'b1;
        end else begin
            value = shifted[D_WIDTH-1:0];
            clip  = 1'b0;
        end
    end

endmodule

// File: rtl/clarke_pipe.sv
// clarke_pipe: 3-stage pipelined Clarke transform (sum, multiply, scale)
// with valid/ready backpressure and a channel tag riding with each sample.
// Build option CLARKE_ROUND_EN selects round-half-up in the scale stage.
module clarke_pipe
    import clarke_pkg::*;
#(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15,
    parameter int CH_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [CH_BITS-1:0]        in_ch,
    input  logic signed [D_WIDTH-1:0] a,
    input  logic signed [D_WIDTH-1:0] b,
    input  logic signed [D_WIDTH-1:0] c,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [D_WIDTH-1:0] alpha,
    output logic signed [D_WIDTH-1:0] beta,
    output logic [CH_BITS-1:0]        out_ch,
    output logic                      out_sat
);

    localparam int S_WIDTH = D_WIDTH + 2;
    localparam int P_WIDTH = D_WIDTH + Q_BITS + 3;
    localparam int K_WIDTH = Q_BITS + 2;

    localparam logic signed [K_WIDTH-1:0] K_ONE   = K_WIDTH'(coef_one(Q_BITS));
    localparam logic signed [K_WIDTH-1:0] K_ISQ3  = K_WIDTH'(coef_one_div_sqrt3(Q_BITS));
    localparam logic signed [K_WIDTH-1:0] K_THIRD = K_WIDTH'(coef_one_third(Q_BITS));

    logic adv;

    clarke_mode_e              mode_in;
    logic signed [S_WIDTH-1:0] a_x, b_x, c_x;
    logic signed [S_WIDTH-1:0] sa_n, sb_n;

    logic                      s1_v;
    clarke_mode_e              s1_mode;
    logic [CH_BITS-1:0]        s1_ch;
    logic signed [S_WIDTH-1:0] s1_sa, s1_sb;

    logic signed [P_WIDTH-1:0] ka_p, kb_p, sa_p, sb_p;
    logic signed [P_WIDTH-1:0] pa_n, pb_n;

    logic                      s2_v;
    logic [CH_BITS-1:0]        s2_ch;
    logic signed [P_WIDTH-1:0] s2_pa, s2_pb;

    logic signed [D_WIDTH-1:0] alpha_n, beta_n;
    logic                      clip_a, clip_b;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign mode_in = clarke_mode_e'(in_mode);
    assign a_x     = {{2{a[D_WIDTH-1]}}, a};
    assign b_x     = {{2{b[D_WIDTH-1]}}, b};
    assign c_x     = {{2{c[D_WIDTH-1]}}, c};

    // S1 combinational sums; c only participates in three-phase mode.
    always_comb begin
        if (mode_in == MODE_3PH) begin
            sa_n = (a_x <<< 1) - b_x - c_x;
            sb_n = b_x - c_x;
        end else begin
            sa_n = a_x;
            sb_n = a_x + (b_x <<< 1);
        end
    end

    // S2 combinational multiply; the alpha gain follows the registered mode.
    always_comb begin
        ka_p = P_WIDTH'((s1_mode == MODE_3PH) ? K_THIRD : K_ONE);
        kb_p = P_WIDTH'(K_ISQ3);
        sa_p = P_WIDTH'(s1_sa);
        sb_p = P_WIDTH'(s1_sb);
        pa_n = sa_p * ka_p;
        pb_n = sb_p * kb_p;
    end

    clarke_scale_sat #(
        .D_WIDTH (D_WIDTH),
        .Q_BITS  (Q_BITS),
        .P_WIDTH (P_WIDTH)
    ) u_scale_alpha (
        .p     (s2_pa),
        .value (alpha_n),
        .clip  (clip_a)
    );

    clarke_scale_sat #(
        .D_WIDTH (D_WIDTH),
        .Q_BITS  (Q_BITS),
        .P_WIDTH (P_WIDTH)
    ) u_scale_beta (
        .p     (s2_pb),
        .value (beta_n),
        .clip  (clip_b)
    );

    // Pipeline registers: shift all stages together on adv, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_mode   <= MODE_2PH;
            s1_ch     <= '0;
            s1_sa     <= '0;
            s1_sb     <= '0;
            s2_v      <= 1'b0;
            s2_ch     <= '0;
            s2_pa     <= '0;
            s2_pb     <= '0;
            out_valid <= 1'b0;
            alpha     <= '0;
            beta      <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            s1_v      <= in_valid;
            s1_mode   <= mode_in;
            s1_ch     <= in_ch;
            s1_sa     <= sa_n;
            s1_sb     <= sb_n;
            s2_v      <= s1_v;
            s2_ch     <= s1_ch;
            s2_pa     <= pa_n;
            s2_pb     <= pb_n;
            out_valid <= s2_v;
            alpha     <= alpha_n;
            beta      <= beta_n;
            out_ch    <= s2_ch;
            out_sat   <= clip_a | clip_b;
        end
    end

endmodule

// File: tb/tb_clarke_pipe.sv
// tb_clarke_pipe: scoreboard bench for clarke_pipe (D_WIDTH=18, Q_BITS=15).
// Expected values are hand-computed for both CLARKE_ROUND_EN builds.
module tb_clarke_pipe;

    localparam int DW = 18;
    localparam int QB = 15;
    localparam int CB = 2;

`ifdef CLARKE_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_mode = 1'b0;
    logic [CB-1:0]        in_ch = '0;
    logic signed [DW-1:0] a = '0;
    logic signed [DW-1:0] b = '0;
    logic signed [DW-1:0] c = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] alpha;
    logic signed [DW-1:0] beta;
    logic [CB-1:0]        out_ch;
    logic                 out_sat;

    clarke_pipe #(
        .D_WIDTH (DW),
        .Q_BITS  (QB),
        .CH_BITS (CB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_ch     (in_ch),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alpha     (alpha),
        .beta      (beta),
        .out_ch    (out_ch),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int al;
        int be;
        int ch;
        int sat;
        int acc;
        bit lat;
    } exp_t;

    typedef struct {
        bit mode;
        int a;
        int b;
        int c;
        int ea;
        int eb;
        int es;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_push = 0;
    int n_pop = 0;
    int stall_at = -100;

    function automatic vec_t mkv(bit mode, int va, int vb, int vc, int ea, int eb, int es);
        vec_t v;
        v.mode = mode;
        v.a = va;
        v.b = vb;
        v.c = vc;
        v.ea = ea;
        v.eb = eb;
        v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream backpressure: four stalled cycles starting at stall_at.
    always @(negedge clk) out_ready = !(cyc >= stall_at && cyc < stall_at + 4);

    // Monitor: compare whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            if (out_valid && !out_ready) check("in_ready_stall", int'(in_ready), 0);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=ch%0d/%0d/%0d required=none", out_ch, alpha, beta);
                end else begin
                    e = sb_q[0];
                    check("alpha", int'(alpha), e.al);
                    check("beta", int'(beta), e.be);
                    check("out_ch", int'(out_ch), e.ch);
                    check("out_sat", int'(out_sat), e.sat);
                    if (e.lat) begin
                        check("latency", cyc - e.acc, 3);
                        e.lat = 1'b0;
                        sb_q[0] = e;
                    end
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    task automatic send(input int idx, input int ch, input bit lat);
        exp_t e;
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = vecs[idx].mode;
        in_ch    = CB'(ch);
        a        = DW'(vecs[idx].a);
        b        = DW'(vecs[idx].b);
        c        = DW'(vecs[idx].c);
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready0 required=in_ready1");
        end else begin
            e.al  = vecs[idx].ea;
            e.be  = vecs[idx].eb;
            e.ch  = ch;
            e.sat = vecs[idx].es;
            e.acc = cyc;
            e.lat = lat;
            sb_q.push_back(e);
            n_push++;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mkv(1'b0,  16384,      0,     0,  16384,  RND ? 9460 : 9459, 0);
        vecs[1] = mkv(1'b0, -16384,      0,     0, -16384,  RND ? -9459 : -9460, 0);
        vecs[2] = mkv(1'b1,  16384,  -8192, -8192,  RND ? 16385 : 16384, 0, 0);
        vecs[3] = mkv(1'b1,      0,   8192, -8192,      0,  RND ? 9460 : 9459, 0);
        vecs[4] = mkv(1'b0, 131071, 131071,     0, 131071,  131071, 1);
        vecs[5] = mkv(1'b0, -131072, -131072,   0, -131072, -131072, 1);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_alpha", int'(alpha), 0);
        check("rst_beta", int'(beta), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_out_sat", int'(out_sat), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", int'(in_ready), 1);

        // Isolated samples: values plus exact latency.
        for (int i = 0; i < 6; i++) begin
            send(i, i % 4, 1'b1);
            idle();
            drain(20);
        end

        // Back-to-back stream with a 4-cycle stall in the middle.
        @(negedge clk);
        stall_at = cyc + 5;
        for (int k = 0; k < 6; k++) begin
            send(k, k % 4, 1'b0);
        end
        idle();
        drain(40);
        check("stream_count", n_pop, n_push);

        // Reset with three samples in flight: they must vanish.
        for (int k = 0; k < 3; k++) begin
            send(k + 2, k + 1, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        n_push -= sb_q.size();
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("flush_out_valid", int'(out_valid), 0);
        check("flush_alpha", int'(alpha), 0);
        check("flush_beta", int'(beta), 0);
        check("flush_out_ch", int'(out_ch), 0);
        check("flush_out_sat", int'(out_sat), 0);
        check("flush_in_ready", int'(in_ready), 1);
        repeat (5) @(negedge clk);

        send(0, 3, 1'b1);
        idle();
        drain(20);
        check("total_count", n_pop, n_push);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
